// File: rtl/polyplay_pkg.sv
// Shared definitions for the PolyPlay ioctl upload path.
//   state_t       : upload responder FSM states
//   IOCTL_ADDR_W  : width of the hps_io ioctl byte address
//   IOCTL_DATA_W  : width of the ioctl data bus
//   PAD_BYTE      : value returned for reads outside the served RAM
package polyplay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_LAT  = 2'd2
  } state_t;

  localparam int IOCTL_ADDR_W = 25;
  localparam int IOCTL_DATA_W = 8;
  localparam logic [IOCTL_DATA_W-1:0] PAD_BYTE = 8'hFF;

endpackage

// File: rtl/ioctl_upload_responder_if.sv
// Bus bundle between hps_io, the upload responder and the core RAM arbiter.
//   ioctl_* : upload read port from hps_io (strobe, address, returned data, stall)
//   mem_*   : request/grant port into the shared core RAM
// Modports:
//   slave  : the responder (consumes ioctl reads, drives the RAM request)
//   master : the environment (hps_io + RAM arbiter side)
interface ioctl_upload_responder_if
  import polyplay_pkg::*;
#(
  parameter int ADDR_W = 10
);
  logic                    ioctl_upload;
  logic [7:0]              ioctl_index;
  logic [IOCTL_ADDR_W-1:0] ioctl_addr;
  logic                    ioctl_rd;
  logic [IOCTL_DATA_W-1:0] ioctl_din;
  logic                    ioctl_wait;
  logic                    mem_req;
  logic                    mem_gnt;
  logic [ADDR_W-1:0]       mem_addr;
  logic [IOCTL_DATA_W-1:0] mem_rdata;

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd, mem_gnt, mem_rdata,
    output ioctl_din, ioctl_wait, mem_req, mem_addr
  );

  modport master (
    output ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd, mem_gnt, mem_rdata,
    input  ioctl_din, ioctl_wait, mem_req, mem_addr
  );
endinterface

// File: rtl/ioctl_upload_responder.sv
// Serves HPS->core upload reads of the hps_io ioctl interface from core RAM
// (high-score / CMOS RAM). Each ioctl_rd for the matching index fetches one
// byte through a request/grant port shared with the CPU, stalling HPS with
// ioctl_wait until the byte is on ioctl_din.
// Ports:
//   clk_sys : system clock
//   reset   : asynchronous active-high reset
//   bus     : ioctl read port + core RAM request port (slave modport)
//   busy    : session active for UPLOAD_INDEX (registered, one cycle late)
//   done    : one-cycle pulse when the session ends
// Optional feature, macro UPLOAD_CSUM_EN: keeps a running byte sum of served
// RAM bytes; a read at addr == MEM_SIZE returns the two's complement of it so
// that the whole uploaded image sums to zero.
module ioctl_upload_responder
  import polyplay_pkg::*;
#(
  parameter logic [7:0] UPLOAD_INDEX = 8'd2,
  parameter int         ADDR_W       = 10,
  parameter int         MEM_SIZE     = 1024,
  parameter int         RD_LAT       = 1
) (
  input  logic                            clk_sys,
  input  logic                            reset,
  ioctl_upload_responder_if.slave         bus,
  output logic                            busy,
  output logic                            done
);

  localparam logic [IOCTL_ADDR_W-1:0] MEM_SIZE_A = IOCTL_ADDR_W'(MEM_SIZE);
  localparam logic [1:0]              LAT_LOAD   = 2'(RD_LAT - 1);

  state_t                  state_reg, state_next;
  logic                    mem_req_reg, mem_req_next;
  logic [ADDR_W-1:0]       mem_addr_reg, mem_addr_next;
  logic                    wait_reg, wait_next;
  logic [IOCTL_DATA_W-1:0] din_reg, din_next;
  logic [1:0]              lat_cnt_reg, lat_cnt_next;
  logic                    busy_reg;
  logic                    done_reg, done_next;

  logic sel, sel_fall, in_range;
  logic [IOCTL_DATA_W-1:0] pad_value;

  assign sel      = bus.ioctl_upload && (bus.ioctl_index == UPLOAD_INDEX);
  // busy_reg is sel delayed by one cycle, so it doubles as the edge detector.
  assign sel_fall = busy_reg && !sel;
  // Full-width compare: addresses beyond 2**ADDR_W must not alias into RAM.
  assign in_range = bus.ioctl_addr < MEM_SIZE_A;

`ifdef UPLOAD_CSUM_EN
  logic                    sel_rise;
  logic [IOCTL_DATA_W-1:0] sum_reg, sum_next;

  assign sel_rise = sel && !busy_reg;

  // The sum restarts with each session; a checksum read in the very first
  // cycle of a session therefore sees an empty sum.
  always_comb begin
    pad_value = PAD_BYTE;
    if (bus.ioctl_addr == MEM_SIZE_A)
      pad_value = sel_rise ? '0 : (IOCTL_DATA_W'(0) - sum_reg);
  end
`else
  assign pad_value = PAD_BYTE;
`endif

  always_comb begin
    state_next    = state_reg;
    mem_req_next  = mem_req_reg;
    mem_addr_next = mem_addr_reg;
    wait_next     = wait_reg;
    din_next      = din_reg;
    lat_cnt_next  = lat_cnt_reg;
    done_next     = 1'b0;
`ifdef UPLOAD_CSUM_EN
    sum_next      = sum_reg;
`endif

    if (sel_fall) begin
      // Session ended or index changed: drop any outstanding access, keep din.
      state_next   = ST_IDLE;
      mem_req_next = 1'b0;
      wait_next    = 1'b0;
      done_next    = 1'b1;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (bus.ioctl_rd && sel) begin
            if (in_range) begin
              mem_addr_next = bus.ioctl_addr[ADDR_W-1:0];
              mem_req_next  = 1'b1;
              wait_next     = 1'b1;
              state_next    = ST_REQ;
            end else begin
              // Out-of-RAM reads are answered immediately without stalling.
              din_next = pad_value;
            end
          end
        end
        ST_REQ: begin
          if (bus.mem_gnt) begin
            mem_req_next = 1'b0;
            lat_cnt_next = LAT_LOAD;
            state_next   = ST_LAT;
          end
        end
        ST_LAT: begin
          if (lat_cnt_reg == 2'd0) begin
            din_next   = bus.mem_rdata;
            wait_next  = 1'b0;
            state_next = ST_IDLE;
`ifdef UPLOAD_CSUM_EN
            sum_next   = sum_reg + bus.mem_rdata;
`endif
          end else begin
            lat_cnt_next = lat_cnt_reg - 2'd1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end

`ifdef UPLOAD_CSUM_EN
    if (sel_rise)
      sum_next = '0;
`endif
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= '0;
      wait_reg     <= 1'b0;
      din_reg      <= '0;
      lat_cnt_reg  <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mem_req_reg  <= mem_req_next;
      mem_addr_reg <= mem_addr_next;
      wait_reg     <= wait_next;
      din_reg      <= din_next;
      lat_cnt_reg  <= lat_cnt_next;
      busy_reg     <= sel;
      done_reg     <= done_next;
    end
  end

`ifdef UPLOAD_CSUM_EN
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      sum_reg <= '0;
    else
      sum_reg <= sum_next;
  end
`endif

  assign bus.mem_req    = mem_req_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.ioctl_wait = wait_reg;
  assign bus.ioctl_din  = din_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;

endmodule

// File: tb/tb_ioctl_upload_responder.sv
module tb_ioctl_upload_responder;

  logic clk_sys = 1'b0;
  logic reset;
  logic busy, done;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] ram [0:1023];

  ioctl_upload_responder_if #(.ADDR_W(10)) io ();

  ioctl_upload_responder #(
    .UPLOAD_INDEX(8'd2), .ADDR_W(10), .MEM_SIZE(1024), .RD_LAT(1)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (io.slave),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk_sys = ~clk_sys;

  // Core RAM model, read latency 1 after grant.
  always @(posedge clk_sys)
    if (io.mem_req && io.mem_gnt) io.mem_rdata <= ram[io.mem_addr];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    if (io.ioctl_din !== 8'h00) begin errors++; $display("FAIL reset_din got %h expected 00", io.ioctl_din); end
    checks++;
    if (io.ioctl_wait !== 1'b0) begin errors++; $display("FAIL reset_wait got %b expected 0", io.ioctl_wait); end
    checks++;
    if (io.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b expected 0", io.mem_req); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b expected 00", busy, done); end
    checks++;
    reset = 1'b0;
    $display("reset: checked idle outputs");
  endtask

  task automatic test_basic_read();
    io.ioctl_upload = 1'b1; io.ioctl_index = 8'd2;
    tick();
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b expected 1", busy); end
    checks++;
    io.ioctl_addr = 25'd5; io.ioctl_rd = 1'b1;
    tick(); io.ioctl_rd = 1'b0;
    if (io.ioctl_wait !== 1'b1 || io.mem_req !== 1'b1) begin
      errors++; $display("FAIL basic_n1 wait/req got %b%b expected 11", io.ioctl_wait, io.mem_req); end
    checks++;
    if (io.mem_addr !== 10'd5) begin errors++; $display("FAIL basic_addr got %0d expected 5", io.mem_addr); end
    checks++;
    tick();
    if (io.ioctl_wait !== 1'b1 || io.mem_req !== 1'b0) begin
      errors++; $display("FAIL basic_n2 wait/req got %b%b expected 10", io.ioctl_wait, io.mem_req); end
    checks++;
    tick();
    if (io.ioctl_din !== 8'h3C || io.ioctl_wait !== 1'b0) begin
      errors++; $display("FAIL basic_n3 din/wait got %h/%b expected 3c/0", io.ioctl_din, io.ioctl_wait); end
    checks++;
    $display("basic_read: addr 5 -> %h", io.ioctl_din);
  endtask

  task automatic test_gnt_stall();
    io.mem_gnt = 1'b0;
    io.ioctl_addr = 25'd7; io.ioctl_rd = 1'b1;
    tick(); io.ioctl_rd = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (io.mem_req !== 1'b1 || io.ioctl_wait !== 1'b1 || io.mem_addr !== 10'd7) begin
        errors++; $display("FAIL stall_hold cyc %0d req/wait/addr got %b/%b/%0d expected 1/1/7",
                            i, io.mem_req, io.ioctl_wait, io.mem_addr); end
      checks++;
      tick();
    end
    io.mem_gnt = 1'b1;
    tick();
    if (io.mem_req !== 1'b0 || io.ioctl_wait !== 1'b1) begin
      errors++; $display("FAIL stall_gnt req/wait got %b/%b expected 0/1", io.mem_req, io.ioctl_wait); end
    checks++;
    tick();
    if (io.ioctl_din !== 8'hA5 || io.ioctl_wait !== 1'b0) begin
      errors++; $display("FAIL stall_data din/wait got %h/%b expected a5/0", io.ioctl_din, io.ioctl_wait); end
    checks++;
    $display("gnt_stall: addr 7 -> %h after 10 stall cycles", io.ioctl_din);
  endtask

  task automatic test_other_index();
    io.ioctl_index = 8'd0;
    tick();
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL index_change done/busy got %b/%b expected 1/0", done, busy); end
    checks++;
    io.ioctl_addr = 25'd5; io.ioctl_rd = 1'b1;
    tick(); io.ioctl_rd = 1'b0;
    if (done !== 1'b0) begin errors++; $display("FAIL index_done_pulse got %b expected 0", done); end
    checks++;
    if (io.mem_req !== 1'b0 || io.ioctl_wait !== 1'b0 || io.ioctl_din !== 8'hA5) begin
      errors++; $display("FAIL index_ignore_in req/wait/din got %b/%b/%h expected 0/0/a5",
                          io.mem_req, io.ioctl_wait, io.ioctl_din); end
    checks++;
    io.ioctl_addr = 25'd2000; io.ioctl_rd = 1'b1;
    tick(); io.ioctl_rd = 1'b0;
    if (io.ioctl_din !== 8'hA5 || busy !== 1'b0) begin
      errors++; $display("FAIL index_ignore_out din/busy got %h/%b expected a5/0", io.ioctl_din, busy); end
    checks++;
    io.ioctl_index = 8'd2;
    tick();
    $display("other_index: strobes ignored, din %h", io.ioctl_din);
  endtask

  task automatic test_out_of_range();
    logic [24:0] addrs [3];
    int n;
    addrs[0] = 25'd1025; addrs[1] = 25'd70000; addrs[2] = 25'd1024;
`ifdef UPLOAD_CSUM_EN
    n = 2;
`else
    n = 3;
`endif
    for (int i = 0; i < n; i++) begin
      io.ioctl_addr = addrs[i]; io.ioctl_rd = 1'b1;
      tick(); io.ioctl_rd = 1'b0;
      if (io.ioctl_din !== 8'hFF || io.ioctl_wait !== 1'b0 || io.mem_req !== 1'b0) begin
        errors++; $display("FAIL oor_%0d din/wait/req got %h/%b/%b expected ff/0/0",
                            addrs[i], io.ioctl_din, io.ioctl_wait, io.mem_req); end
      checks++;
      tick();
      if (io.ioctl_wait !== 1'b0 || io.mem_req !== 1'b0) begin
        errors++; $display("FAIL oor_after_%0d wait/req got %b/%b expected 0/0",
                            addrs[i], io.ioctl_wait, io.mem_req); end
      checks++;
      $display("out_of_range: addr %0d -> %h", addrs[i], io.ioctl_din);
    end
  endtask

  task automatic test_abort();
    io.mem_gnt = 1'b0;
    io.ioctl_addr = 25'd9; io.ioctl_rd = 1'b1;
    tick(); io.ioctl_rd = 1'b0;
    if (io.mem_req !== 1'b1) begin errors++; $display("FAIL abort_req_up got %b expected 1", io.mem_req); end
    checks++;
    io.ioctl_upload = 1'b0;
    tick();
    if (io.mem_req !== 1'b0 || io.ioctl_wait !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL abort req/wait/done got %b/%b/%b expected 0/0/1", io.mem_req, io.ioctl_wait, done); end
    checks++;
    tick();
    if (done !== 1'b0 || io.ioctl_din !== 8'hFF) begin
      errors++; $display("FAIL abort_after done/din got %b/%h expected 0/ff", done, io.ioctl_din); end
    checks++;
    io.ioctl_upload = 1'b1; io.mem_gnt = 1'b1;
    tick();
    io.ioctl_addr = 25'd5; io.ioctl_rd = 1'b1;
    tick(); io.ioctl_rd = 1'b0;
    tick(); tick();
    if (io.ioctl_din !== 8'h3C || io.ioctl_wait !== 1'b0) begin
      errors++; $display("FAIL abort_next_session din/wait got %h/%b expected 3c/0", io.ioctl_din, io.ioctl_wait); end
    checks++;
    $display("abort: session restarted, addr 5 -> %h", io.ioctl_din);
  endtask

  task automatic test_reset_mid_lat();
    io.ioctl_addr = 25'd7; io.ioctl_rd = 1'b1;
    tick(); io.ioctl_rd = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    if (io.ioctl_din !== 8'h00 || io.ioctl_wait !== 1'b0 || io.mem_req !== 1'b0 ||
        io.mem_addr !== 10'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_mid_lat din/wait/req/addr/busy/done got %h/%b/%b/%0d/%b/%b expected 00/0/0/0/0/0",
                          io.ioctl_din, io.ioctl_wait, io.mem_req, io.mem_addr, busy, done); end
    checks++;
    #1 reset = 1'b0;
    tick();
    if (busy !== 1'b1 || io.ioctl_wait !== 1'b0) begin
      errors++; $display("FAIL reset_release busy/wait got %b/%b expected 1/0", busy, io.ioctl_wait); end
    checks++;
    $display("reset_mid_lat: outputs cleared asynchronously");
  endtask

`ifdef UPLOAD_CSUM_EN
  task automatic test_checksum();
    logic [7:0] exp_din;
    for (int i = 0; i < 4; i++) begin
      io.ioctl_addr = 25'(i); io.ioctl_rd = 1'b1;
      tick(); io.ioctl_rd = 1'b0;
      tick(); tick();
      exp_din = 8'(i + 1);
      if (io.ioctl_din !== exp_din) begin
        errors++; $display("FAIL csum_byte%0d got %h expected %h", i, io.ioctl_din, exp_din); end
      checks++;
    end
    io.ioctl_addr = 25'd1024; io.ioctl_rd = 1'b1;
    tick(); io.ioctl_rd = 1'b0;
    if (io.ioctl_din !== 8'hF6 || io.mem_req !== 1'b0 || io.ioctl_wait !== 1'b0) begin
      errors++; $display("FAIL csum_value din/req/wait got %h/%b/%b expected f6/0/0",
                          io.ioctl_din, io.mem_req, io.ioctl_wait); end
    checks++;
    $display("checksum: sum byte %h", io.ioctl_din);
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i * 7 + 3);
    ram[0] = 8'h01; ram[1] = 8'h02; ram[2] = 8'h03; ram[3] = 8'h04;
    ram[5] = 8'h3C; ram[7] = 8'hA5; ram[9] = 8'h5A;
    io.ioctl_upload = 1'b0; io.ioctl_index = 8'd0; io.ioctl_addr = '0;
    io.ioctl_rd = 1'b0; io.mem_gnt = 1'b1; io.mem_rdata = 8'h00;
    reset = 1'b1;

    test_reset();
    test_basic_read();
    test_gnt_stall();
    test_other_index();
    test_out_of_range();
    test_abort();
    test_reset_mid_lat();
`ifdef UPLOAD_CSUM_EN
    test_checksum();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
